// File: rtl/mux_2x1_rr_arbiter_if.sv
// Handshake and data bundle between two sources and the 2:1 round-robin arbiter.
// Optional MUX_ARB_LOCK_EN adds a lock input that lets the current owner hold the path.
interface mux_2x1_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_a;
    logic             req_b;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;
`endif
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             sel;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;

`ifdef MUX_ARB_LOCK_EN
    modport master (
        output req_a, req_b, lock, data_a, data_b,
        input  gnt_a, gnt_b, sel, data_out, valid_out
    );

    modport slave (
        input  req_a, req_b, lock, data_a, data_b,
        output gnt_a, gnt_b, sel, data_out, valid_out
    );
`else
    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel, data_out, valid_out
    );

    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel, data_out, valid_out
    );
`endif
endinterface

// File: rtl/mux_2x1_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux plus a registered data copy.
// Optional MUX_ARB_LOCK_EN: lock lets the current owner ignore the HOLD_MAX limit.
module mux_2x1_rr_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    mux_2x1_rr_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state;
    logic             last_served;
    logic [CNT_W-1:0] hold_cnt;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             sel_r;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    logic             lock_c;
    logic             hold_ok_c;
    logic             keep_a_c;
    logic             keep_b_c;
    logic [CNT_W-1:0] hold_inc_c;
    logic             go_a_c;
    logic             go_b_c;
    logic             stay_c;

`ifdef MUX_ARB_LOCK_EN
    assign lock_c = bus.lock;
`else
    assign lock_c = 1'b0;
`endif

    // Owner may stay while its hold budget is not exhausted, or while locked.
    assign hold_ok_c  = (hold_cnt != HOLD_LAST) || lock_c;
    assign keep_a_c   = bus.req_a && (!bus.req_b || hold_ok_c);
    assign keep_b_c   = bus.req_b && (!bus.req_a || hold_ok_c);
    assign hold_inc_c = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + CNT_W'(1);

    // Next-owner decision; at most one of go_a_c/go_b_c/stay_c is set.
    always_comb begin
        go_a_c = 1'b0;
        go_b_c = 1'b0;
        stay_c = 1'b0;
        unique case (state)
            IDLE: begin
                go_a_c = bus.req_a && (!bus.req_b || (last_served == SIDE_B));
                go_b_c = bus.req_b && !go_a_c;
            end
            OWN_A: begin
                stay_c = keep_a_c;
                go_b_c = !keep_a_c && bus.req_b;
            end
            OWN_B: begin
                stay_c = keep_b_c;
                go_a_c = !keep_b_c && bus.req_a;
            end
            default: begin
                go_a_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_served <= SIDE_B;
            hold_cnt    <= '0;
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            sel_r       <= 1'b0;
            data_r      <= '0;
            valid_r     <= 1'b0;
        end else begin
            // Transfer uses the grant held before this edge.
            if (gnt_a_r && bus.req_a) begin
                data_r  <= bus.data_a;
                valid_r <= 1'b1;
            end else if (gnt_b_r && bus.req_b) begin
                data_r  <= bus.data_b;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end

            if (go_a_c) begin
                state       <= OWN_A;
                last_served <= SIDE_A;
                hold_cnt    <= '0;
                gnt_a_r     <= 1'b1;
                gnt_b_r     <= 1'b0;
                sel_r       <= 1'b0;
            end else if (go_b_c) begin
                state       <= OWN_B;
                last_served <= SIDE_B;
                hold_cnt    <= '0;
                gnt_a_r     <= 1'b0;
                gnt_b_r     <= 1'b1;
                sel_r       <= 1'b1;
            end else if (stay_c) begin
                hold_cnt    <= hold_inc_c;
            end else begin
                // sel keeps its last value while idle.
                state       <= IDLE;
                hold_cnt    <= '0;
                gnt_a_r     <= 1'b0;
                gnt_b_r     <= 1'b0;
            end
        end
    end

    assign bus.gnt_a     = gnt_a_r;
    assign bus.gnt_b     = gnt_b_r;
    assign bus.sel       = sel_r;
    assign bus.data_out  = data_r;
    assign bus.valid_out = valid_r;

endmodule

// File: doc/mux_2x1_rr_arbiter.md
Name: mux_2x1_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 select path between source A and source B.
- Grants ownership through a req/gnt handshake and drives the select line for the 2x1 multiplexer datapath.
- Also produces a registered, validated copy of the selected data.
- Sits directly in front of the 2x1 mux; callers never drive the select themselves.

Parameters:
- WIDTH, 8, data width of data_a / data_b / data_out.
- HOLD_MAX, 4, max consecutive cycles one owner keeps the grant while the other side is requesting. Legal range is >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_a  input  1  source A requests the path
- req_b  input  1  source B requests the path
- data_a  input  WIDTH  source A data
- data_b  input  WIDTH  source B data
- gnt_a  output  1  A owns the path (registered)
- gnt_b  output  1  B owns the path (registered)
- sel  output  1  mux select; 0 = A, 1 = B (registered)
- data_out  output  WIDTH  registered selected data
- valid_out  output  1  data_out holds a transfer from the previous edge

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high; it takes effect on the clk edge where it is sampled high.
- Reset values:
  - state=IDLE
  - gnt_a=0, gnt_b=0, sel=0
  - data_out=0, valid_out=0
  - hold_cnt=0
  - last_served=B, so A wins the first contention
- Reset mid-operation: the next edge forces all reset values, regardless of state or requests.
- States: IDLE, OWN_A, OWN_B. gnt_a=1 only in OWN_A; gnt_b=1 only in OWN_B. gnt_a&gnt_b is never 1.
- IDLE transitions:
  - req_a&req_b: go to OWN of the side != last_served.
  - only req_a: go to OWN_A.
  - only req_b: go to OWN_B.
  - no request: stay in IDLE.
- OWN_X transitions (Y = the other side):
  - req_x=1 and (req_y=0 or hold_cnt<HOLD_MAX-1): stay in OWN_X; hold_cnt+1, saturating at HOLD_MAX-1.
  - req_x=1, req_y=1, hold_cnt==HOLD_MAX-1: go to OWN_Y.
  - req_x=0, req_y=1: go to OWN_Y with no idle bubble.
  - req_x=0, req_y=0: go to IDLE.
  - On every entry to an OWN state: hold_cnt=0 and last_served updated to the new owner.
- sel: 0 in OWN_A, 1 in OWN_B. In IDLE it holds its previous value.
- Latency:
  - req asserted before edge k gives gnt=1 after edge k.
  - A transfer occurs on any edge where gnt_x=1 and req_x=1. That edge loads data_out<=data_x and valid_out<=1.
  - On any other edge valid_out<=0 and data_out holds its value.
- A requester dropping req while granted loses the grant on that same edge. No transfer is taken on that edge.
- HOLD_MAX=1 under continuous contention alternates the grant every cycle.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit, after req_b).
  - While the current owner has req_x=1 and lock=1, the HOLD_MAX limit is ignored and ownership is kept.
  - hold_cnt still saturates.
  - On lock deassertion with hold_cnt==HOLD_MAX-1 and the other side requesting, the grant switches on the next edge.
- Undefined: the port is absent and behaviour is identical to lock=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req → gnt_a=gnt_b=0, sel=0, valid_out=0, data_out=0x00.
- Single requester: req_a=1, data_a=0x3C held for 5 cycles, req_b=0 → gnt_a=1 from the first edge, sel=0, valid_out=1 from the second edge, data_out=0x3C, never switches.
- Contention with HOLD_MAX=4: req_a=req_b=1 continuously, data_a=0xAA, data_b=0x55 → grants run A,A,A,A,B,B,B,B,A…; data_out follows 0xAA×4, 0x55×4 one edge later; gnt never overlaps.
- Early release: owner B with req_a=1 waiting; drop req_b after 2 cycles → OWN_A on the same edge, no IDLE cycle, sel=0; valid_out=0 for exactly one edge (the edge where B dropped), then data_out=data_a.
- Reset mid-operation: assert rst during OWN_B with hold_cnt=2 → next edge gnt_b=0, sel=0, valid_out=0; after release, with both requesting, A is granted first.
- MUX_ARB_LOCK_EN: owner A with lock=1 and req_b=1 for 10 cycles → gnt_a stays 1 all 10 cycles; lock=0 → gnt_b=1 on the next edge.
